// File: rtl/count_pwm_pkg.sv
// Shared constants and FSM encoding for the counter-driven PWM block.
package count_pwm_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/count_monitor.sv
// Watches the 4-bit count stream: flags wraps (15->0) and any step that is not +1.
module count_monitor
  import count_pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] c,
  output logic             wrap_det,
  output logic             skip_det,
  output logic             glitch
);

  logic [CNT_W-1:0] prev_c;
  logic             prev_valid;
  logic [CNT_W-1:0] prev_inc;

  // prev_valid gates both detectors so the first edge after reset only primes prev_c
  assign prev_inc = prev_c + CNT_W'(1);
  assign wrap_det = prev_valid && (prev_c == CNT_MAX) && (c == '0);
  assign skip_det = prev_valid && (c != prev_inc);

  always_ff @(posedge clk) begin
    prev_c <= c;
    if (rst) begin
      prev_valid <= 1'b0;
      glitch     <= 1'b0;
    end else begin
      prev_valid <= 1'b1;
      glitch     <= glitch | skip_det;
    end
  end

endmodule

// File: rtl/count_pwm.sv
// PWM generator driven by an external free-running 4-bit counter; duty is
// double-buffered and only changes at count wrap.
module count_pwm
  import count_pwm_pkg::*;
#(
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q0,
  input  logic              q1,
  input  logic              q2,
  input  logic              q3,
  input  logic              en,
  input  logic [3:0]        duty,
  input  logic              duty_wr,
  output logic              pwm,
  output logic              wrap,
  output logic              running,
  output logic [PCNT_W-1:0] period_cnt,
  output logic              glitch
);

  logic [CNT_W-1:0] c;
  logic             wrap_det;
  logic             skip_det;
  logic [CNT_W-1:0] duty_pend;
  logic [CNT_W-1:0] duty_act;
  state_t           state;

  assign c = {q3, q2, q1, q0};

  function automatic logic [PCNT_W-1:0] sat_inc(input logic [PCNT_W-1:0] v);
    return (v == {PCNT_W{1'b1}}) ? v : v + PCNT_W'(1);
  endfunction

  count_monitor u_mon (
    .clk      (clk),
    .rst      (rst),
    .c        (c),
    .wrap_det (wrap_det),
    .skip_det (skip_det),
    .glitch   (glitch)
  );

  // At a wrap, pwm uses duty_pend directly because duty_act is being loaded from it on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pwm        <= 1'b0;
      wrap       <= 1'b0;
      running    <= 1'b0;
      period_cnt <= '0;
      duty_pend  <= '0;
      duty_act   <= '0;
    end else begin
      wrap <= wrap_det;
      if (duty_wr)  duty_pend <= duty;
      if (wrap_det) duty_act  <= duty_pend;
      case (state)
        IDLE: begin
          pwm <= 1'b0;
          if (en) begin
            state      <= ARM;
            period_cnt <= '0;
          end
        end
        ARM: begin
          pwm <= 1'b0;
          if (!en) begin
            state <= IDLE;
          end else if (wrap_det) begin
            state   <= RUN;
            running <= 1'b1;
            pwm     <= (duty_pend != '0);
          end
        end
        RUN: begin
          if (wrap_det) begin
            period_cnt <= sat_inc(period_cnt);
            if (en) begin
              pwm <= (duty_pend != '0);
            end else begin
              state   <= IDLE;
              running <= 1'b0;
              pwm     <= 1'b0;
            end
          end else begin
            pwm <= (c < duty_act);
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          pwm     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_pwm.sv
// Bench for count_pwm: drives the count stream directly, period table plus
// hand-written reset/glitch sequences, expectations queued per edge.
module tb_count_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic       q0, q1, q2, q3;
  logic       en;
  logic [3:0] duty;
  logic       duty_wr;
  logic       pwm, wrap, running, glitch;
  logic [7:0] period_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct packed {
    logic       p;
    logic       w;
    logic       r;
    logic [7:0] pc;
    logic       g;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic       wr;
    logic [3:0] d;
    logic       en0;
    logic       en1;
    int         hi;
    logic       run;
    logic [7:0] pc;
    logic       skip;
  } per_t;

  per_t tab[13];
  logic xg;

  count_pwm #(.PCNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .q0         (q0),
    .q1         (q1),
    .q2         (q2),
    .q3         (q3),
    .en         (en),
    .duty       (duty),
    .duty_wr    (duty_wr),
    .pwm        (pwm),
    .wrap       (wrap),
    .running    (running),
    .period_cnt (period_cnt),
    .glitch     (glitch)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h, want %0h", nm, cyc, act, want);
    end
  endtask

  task automatic step(input logic [3:0] cv, input logic e, input logic [3:0] d,
                      input logic dw, input logic r,
                      input logic xp, input logic xw, input logic xr,
                      input logic [7:0] xc, input logic xgl);
    exp_t got;
    {q3, q2, q1, q0} = cv;
    en      = e;
    duty    = d;
    duty_wr = dw;
    rst     = r;
    exp_q.push_back({xp, xw, xr, xc, xgl});
    @(posedge clk);
    #1;
    cyc++;
    got = exp_q.pop_front();
    check("pwm", {31'd0, pwm}, {31'd0, got.p});
    check("wrap", {31'd0, wrap}, {31'd0, got.w});
    check("running", {31'd0, running}, {31'd0, got.r});
    check("period_cnt", {24'd0, period_cnt}, {24'd0, got.pc});
    check("glitch", {31'd0, glitch}, {31'd0, got.g});
  endtask

  initial begin
    //            wr    d      en0   en1   hi  run   pc     skip
    tab[0]  = '{1'b0, 4'd0,  1'b1, 1'b1, 5,  1'b1, 8'd0, 1'b0};
    tab[1]  = '{1'b0, 4'd0,  1'b1, 1'b1, 5,  1'b1, 8'd1, 1'b0};
    tab[2]  = '{1'b0, 4'd0,  1'b1, 1'b1, 5,  1'b1, 8'd2, 1'b0};
    tab[3]  = '{1'b1, 4'd12, 1'b1, 1'b1, 5,  1'b1, 8'd3, 1'b0};
    tab[4]  = '{1'b0, 4'd0,  1'b1, 1'b1, 12, 1'b1, 8'd4, 1'b0};
    tab[5]  = '{1'b0, 4'd0,  1'b1, 1'b0, 12, 1'b1, 8'd5, 1'b0};
    tab[6]  = '{1'b0, 4'd0,  1'b0, 1'b0, 0,  1'b0, 8'd6, 1'b0};
    tab[7]  = '{1'b1, 4'd0,  1'b1, 1'b1, 0,  1'b0, 8'd0, 1'b0};
    tab[8]  = '{1'b0, 4'd0,  1'b1, 1'b1, 0,  1'b1, 8'd0, 1'b0};
    tab[9]  = '{1'b1, 4'd15, 1'b1, 1'b1, 0,  1'b1, 8'd1, 1'b0};
    tab[10] = '{1'b0, 4'd0,  1'b1, 1'b1, 15, 1'b1, 8'd2, 1'b0};
    tab[11] = '{1'b0, 4'd0,  1'b1, 1'b1, 15, 1'b1, 8'd3, 1'b0};
    tab[12] = '{1'b0, 4'd0,  1'b1, 1'b1, 15, 1'b1, 8'd4, 1'b1};
    xg = 1'b0;

    // Reset with the counter also stuck at 0: nothing may fire.
    step(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Start mid-period with duty 5 requested; output stays low until the wrap.
    for (int k = 7; k < 16; k++)
      step(k[3:0], 1'b1, 4'd5, k == 7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < 16; k++) begin
        if (tab[i].skip && k == 8) continue;
        if (tab[i].skip && k == 9) xg = 1'b1;
        step(k[3:0], (k < 3) ? tab[i].en0 : tab[i].en1, tab[i].d,
             tab[i].wr && (k == 0), 1'b0,
             k < tab[i].hi, k == 0, tab[i].run, tab[i].pc, xg);
      end
    end

    // One-cycle reset on the c=15 edge of a running period.
    for (int k = 0; k < 15; k++)
      step(k[3:0], 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, k == 0, 1'b1, 8'd5, 1'b1);
    step(4'd15, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // First wrap after reset is unseen (prev_valid still 0); block arms instead.
    step(4'd0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    for (int k = 1; k < 16; k++)
      step(k[3:0], 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Second wrap after reset enters RUN at duty 5.
    for (int k = 0; k < 16; k++)
      step(k[3:0], 1'b1, 4'd0, 1'b0, 1'b0, k < 5, k == 0, 1'b1, 8'd0, 1'b0);
    step(4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0);

    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
